// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter that shares one Vedic multiplier between N_REQ requesters.
// One transaction is in flight at a time: accept, issue A/B, wait for product, deliver.
module vedic_mul_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*DATA_W-1:0] s_req_a_tdata,
    input  logic [N_REQ*DATA_W-1:0] s_req_b_tdata,
    input  logic [N_REQ-1:0]        s_req_tvalid,
    output logic [N_REQ-1:0]        s_req_tready,
    output logic [2*DATA_W-1:0]     m_req_result_tdata,
    output logic [N_REQ-1:0]        m_req_tvalid,
    input  logic [N_REQ-1:0]        m_req_tready,
    output logic [DATA_W-1:0]       mul_a_tdata,
    output logic                    mul_a_tvalid,
    input  logic                    mul_a_tready,
    output logic [DATA_W-1:0]       mul_b_tdata,
    output logic                    mul_b_tvalid,
    input  logic                    mul_b_tready,
    input  logic [2*DATA_W-1:0]     mul_result_tdata,
    input  logic                    mul_result_tvalid,
    output logic                    mul_result_tready,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [15:0]             txn_count
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
    localparam logic [ID_W:0] NReqW = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LastId = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]   a_hold_q, a_hold_d;
    logic [DATA_W-1:0]   b_hold_q, b_hold_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic                a_pend_q, a_pend_d;
    logic                b_pend_q, b_pend_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [15:0]         txn_q, txn_d;

    logic                sel_found;
    logic [ID_W-1:0]     sel_idx;
    logic [ID_W:0]       cand;

    // Cyclic first-valid search starting at rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            if (cand >= NReqW) begin
                cand = cand - NReqW;
            end
            if (!sel_found && s_req_tvalid[cand[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        a_hold_d = a_hold_q;
        b_hold_d = b_hold_q;
        prod_d   = prod_q;
        a_pend_d = a_pend_q & ~mul_a_tready;
        b_pend_d = b_pend_q & ~mul_b_tready;
        cnt_d    = cnt_q;
        err_d    = err_q;
        txn_d    = txn_q;

        s_req_tready       = '0;
        m_req_tvalid       = '0;
        m_req_result_tdata = '0;
        mul_result_tready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    s_req_tready[sel_idx] = 1'b1;
                    a_hold_d = s_req_a_tdata[sel_idx*DATA_W +: DATA_W];
                    b_hold_d = s_req_b_tdata[sel_idx*DATA_W +: DATA_W];
                    grant_d  = sel_idx;
                    a_pend_d = 1'b1;
                    b_pend_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (!a_pend_d && !b_pend_d) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                mul_result_tready = 1'b1;
                if (mul_result_tvalid) begin
                    prod_d  = mul_result_tdata;
                    state_d = StDeliver;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    prod_d  = '0;
                    state_d = StDeliver;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDeliver: begin
                m_req_tvalid[grant_q] = 1'b1;
                m_req_result_tdata    = prod_q;
                if (m_req_tready[grant_q]) begin
                    rr_ptr_d = (grant_q == LastId) ? '0 : grant_q + ID_W'(1);
                    txn_d    = txn_q + 16'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            a_hold_q <= '0;
            b_hold_q <= '0;
            prod_q   <= '0;
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            txn_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            a_hold_q <= a_hold_d;
            b_hold_q <= b_hold_d;
            prod_q   <= prod_d;
            a_pend_q <= a_pend_d;
            b_pend_q <= b_pend_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            txn_q    <= txn_d;
        end
    end

    // Pending flags are only ever set while in ISSUE.
    assign mul_a_tvalid = a_pend_q;
    assign mul_b_tvalid = b_pend_q;
    assign mul_a_tdata  = a_hold_q;
    assign mul_b_tdata  = b_hold_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q != StIdle);
    assign err_timeout  = err_q;
    assign txn_count    = txn_q;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Directed bench for vedic_mul_arbiter (N_REQ=4, DATA_W=2, TIMEOUT=8); the bench
// plays both the requesters and the multiplier.
module tb_vedic_mul_arbiter;

    logic        clk;
    logic        rst;
    logic [7:0]  a_bus;
    logic [7:0]  b_bus;
    logic [3:0]  s_req_tvalid;
    logic [3:0]  s_req_tready;
    logic [3:0]  m_req_result_tdata;
    logic [3:0]  m_req_tvalid;
    logic [3:0]  m_req_tready;
    logic [1:0]  mul_a_tdata;
    logic        mul_a_tvalid;
    logic        mul_a_tready;
    logic [1:0]  mul_b_tdata;
    logic        mul_b_tvalid;
    logic        mul_b_tready;
    logic [3:0]  mul_result_tdata;
    logic        mul_result_tvalid;
    logic        mul_result_tready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_timeout;
    logic [15:0] txn_count;

    int n_chk;
    int n_pass;
    int n_fail;

    vedic_mul_arbiter #(
        .N_REQ  (4),
        .DATA_W (2),
        .TIMEOUT(8),
        .ID_W   (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_req_a_tdata     (a_bus),
        .s_req_b_tdata     (b_bus),
        .s_req_tvalid      (s_req_tvalid),
        .s_req_tready      (s_req_tready),
        .m_req_result_tdata(m_req_result_tdata),
        .m_req_tvalid      (m_req_tvalid),
        .m_req_tready      (m_req_tready),
        .mul_a_tdata       (mul_a_tdata),
        .mul_a_tvalid      (mul_a_tvalid),
        .mul_a_tready      (mul_a_tready),
        .mul_b_tdata       (mul_b_tdata),
        .mul_b_tvalid      (mul_b_tvalid),
        .mul_b_tready      (mul_b_tready),
        .mul_result_tdata  (mul_result_tdata),
        .mul_result_tvalid (mul_result_tvalid),
        .mul_result_tready (mul_result_tready),
        .grant_id          (grant_id),
        .busy              (busy),
        .err_timeout       (err_timeout),
        .txn_count         (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // One full transaction against an ideal multiplier; requester valids are set by the caller.
    task automatic serve(input int g, input int a, input int b, input int p, input int txn);
        #1;
        chk("accept_tready", 32'(s_req_tready), 32'(1 << g));
        nxt(); #1;
        chk("issue_a_data", 32'(mul_a_tdata), 32'(a));
        chk("issue_b_data", 32'(mul_b_tdata), 32'(b));
        chk("issue_valid", 32'({mul_a_tvalid, mul_b_tvalid}), 32'd3);
        chk("issue_grant", 32'(grant_id), 32'(g));
        chk("issue_no_tready", 32'(s_req_tready), 32'd0);
        nxt();
        mul_result_tvalid = 1'b1;
        mul_result_tdata  = 4'(p);
        #1;
        chk("wait_rdy", 32'(mul_result_tready), 32'd1);
        nxt();
        mul_result_tvalid = 1'b0;
        #1;
        chk("dlv_valid", 32'(m_req_tvalid), 32'(1 << g));
        chk("dlv_data", 32'(m_req_result_tdata), 32'(p));
        nxt(); #1;
        chk("dlv_txn", 32'(txn_count), 32'(txn));
        chk("dlv_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1;
        a_bus = '0; b_bus = '0; s_req_tvalid = '0; m_req_tready = 4'b1111;
        mul_a_tready = 1'b1; mul_b_tready = 1'b1;
        mul_result_tdata = '0; mul_result_tvalid = 1'b0;

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_txn", 32'(txn_count), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_outs", 32'({m_req_tvalid, m_req_result_tdata, mul_a_tvalid, mul_b_tvalid,
                             mul_result_tready, s_req_tready}), 32'd0);

        // Single request: req1 3*2
        a_bus[3:2] = 2'd3; b_bus[3:2] = 2'd2;
        s_req_tvalid = 4'b0010;
        serve(1, 3, 2, 6, 1);
        s_req_tvalid = 4'b0000;
        chk("single_grant", 32'(grant_id), 32'd1);

        // All four valid from rr_ptr=0: grants 0,1,2,3 then 0 again
        do_reset();
        a_bus = {2'd3, 2'd2, 2'd1, 2'd0};
        b_bus = 8'hFF;
        s_req_tvalid = 4'b1111;
        serve(0, 0, 3, 0, 1);
        serve(1, 1, 3, 3, 2);
        serve(2, 2, 3, 6, 3);
        serve(3, 3, 3, 9, 4);
        s_req_tvalid = 4'b1001;
        serve(0, 0, 3, 0, 5);
        s_req_tvalid = 4'b0000;

        // A channel stalled 3 cycles, then requester stalls delivery of 9
        nxt();
        s_req_tvalid = 4'b1000;
        mul_a_tready = 1'b0;
        #1;
        chk("stall_accept", 32'(s_req_tready), 32'b1000);
        nxt();
        s_req_tvalid = 4'b0000;
        #1;
        chk("stall_both_valid", 32'({mul_a_tvalid, mul_b_tvalid}), 32'd3);
        nxt(); #1;
        chk("stall_b_done", 32'({mul_a_tvalid, mul_b_tvalid}), 32'd2);
        chk("stall_no_rrdy", 32'(mul_result_tready), 32'd0);
        nxt(); #1;
        chk("stall_a_held", 32'({mul_a_tvalid, mul_b_tvalid}), 32'd2);
        mul_a_tready = 1'b1;
        nxt(); #1;
        chk("stall_wait_a", 32'(mul_a_tvalid), 32'd0);
        chk("stall_wait_rrdy", 32'(mul_result_tready), 32'd1);
        mul_result_tvalid = 1'b1;
        mul_result_tdata  = 4'd9;
        m_req_tready = 4'b0000;
        nxt();
        mul_result_tvalid = 1'b0;
        s_req_tvalid = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) nxt();
            #1;
            chk("hold_valid", 32'(m_req_tvalid), 32'b1000);
            chk("hold_data", 32'(m_req_result_tdata), 32'd9);
            chk("hold_no_tready", 32'(s_req_tready), 32'd0);
        end
        m_req_tready = 4'b1111;
        nxt(); #1;
        chk("hold_txn", 32'(txn_count), 32'd6);
        chk("hold_next_req", 32'(s_req_tready), 32'b0001);
        s_req_tvalid = 4'b0000;
        nxt(); #1;
        chk("withdraw_idle", 32'(busy), 32'd0);

        // Timeout: multiplier never answers
        s_req_tvalid = 4'b0100;
        #1;
        chk("to_accept", 32'(s_req_tready), 32'b0100);
        nxt();
        s_req_tvalid = 4'b0000;
        nxt(); #1;
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_rrdy", 32'(mul_result_tready), 32'd1);
            chk("to_wait_err", 32'(err_timeout), 32'd0);
            nxt(); #1;
        end
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_dlv_valid", 32'(m_req_tvalid), 32'b0100);
        chk("to_dlv_data", 32'(m_req_result_tdata), 32'd0);
        chk("to_dlv_rrdy", 32'(mul_result_tready), 32'd0);
        nxt(); #1;
        chk("to_txn", 32'(txn_count), 32'd7);
        s_req_tvalid = 4'b0010;
        serve(1, 1, 3, 3, 8);
        s_req_tvalid = 4'b0000;
        chk("to_err_sticky", 32'(err_timeout), 32'd1);

        // Reset while in WAIT; late result must be ignored
        nxt();
        s_req_tvalid = 4'b0001;
        nxt();
        s_req_tvalid = 4'b0000;
        nxt(); #1;
        chk("rw_in_wait", 32'(mul_result_tready), 32'd1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        mul_result_tvalid = 1'b1;
        mul_result_tdata  = 4'hF;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_txn", 32'(txn_count), 32'd0);
        chk("rw_err", 32'(err_timeout), 32'd0);
        chk("rw_grant", 32'(grant_id), 32'd0);
        chk("rw_outs", 32'({m_req_tvalid, m_req_result_tdata, mul_a_tvalid, mul_b_tvalid,
                            mul_result_tready, s_req_tready}), 32'd0);
        nxt();
        mul_result_tvalid = 1'b0;
        #1;
        chk("rw_late_busy", 32'(busy), 32'd0);
        chk("rw_late_valid", 32'(m_req_tvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
